// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: memop encodings, access sizes, FSM states.
// No logic latency and no flow control of its own; definitions only.
package dmem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  // Low two memop bits carry the size; the unused load encodings 011/110/111 fall onto word.
  function automatic size_t memop_size(input logic [2:0] memop);
    case (memop[1:0])
      2'b00:   memop_size = SZ_B;
      2'b01:   memop_size = SZ_H;
      default: memop_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store lane enables/replication, alignment/legality check, load extract/extend.
// Combinational, zero latency; no handshake.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  memop,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        err,
  output logic [31:0] rdata_ext
);

  size_t       size;
  logic        illegal;
  logic        misalign;
  logic        sign_ld;
  logic [31:0] shifted;

  always_comb begin
    size      = memop_size(memop);
    illegal   = is_store && !(memop inside {MEMOP_B, MEMOP_H, MEMOP_W});
    misalign  = ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));
    err       = illegal || misalign;
    sign_ld   = !memop[2];
    shifted   = rdata >> {addr_lo, 3'b000};
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign_ld & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign_ld & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter onto a single-ported data memory; one outstanding access.
// Grant same cycle as request in IDLE, load data one cycle later; requests held until gnt, no grants in RD_WAIT.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [2:0]        p0_memop,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [2:0]        p1_memop,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t      state, state_nxt;
  logic        last_p1, last_p1_nxt;
  logic        load_gnt;
  logic        rd_port;
  logic [1:0]  rd_addr_lo;
  logic [2:0]  rd_memop;

  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_memop;

  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_err;
  logic [31:0] st_rdata_unused;
  logic [3:0]  ld_be_unused;
  logic [31:0] ld_wdata_unused;
  logic        ld_err;
  logic [31:0] ld_rdata;
  logic        addr_unused;

  // sel=1 picks port 1: it wins when alone, or on contention when port 0 was granted last.
  assign sel       = (p0_req && p1_req) ? !last_p1 : p1_req;
  assign sel_we    = sel ? p1_we    : p0_we;
  assign sel_addr  = sel ? p1_addr  : p0_addr;
  assign sel_wdata = sel ? p1_wdata : p0_wdata;
  assign sel_memop = sel ? p1_memop : p0_memop;

  assign mem_addr    = sel_addr[MEM_AW+1:2];
  assign mem_wdata   = req_wdata;
  assign addr_unused = ^sel_addr[31:MEM_AW+2];

  // Request path: checks the access being granted this cycle and builds the store lanes.
  dmem_lane_align u_req_align (
    .is_store  (sel_we),
    .addr_lo   (sel_addr[1:0]),
    .memop     (sel_memop),
    .wdata     (sel_wdata),
    .rdata     (32'h0),
    .be        (req_be),
    .wdata_rep (req_wdata),
    .err       (req_err),
    .rdata_ext (st_rdata_unused)
  );

  // Load path: re-evaluates the latched load so RD_WAIT needs no separate error flop.
  dmem_lane_align u_ld_align (
    .is_store  (1'b0),
    .addr_lo   (rd_addr_lo),
    .memop     (rd_memop),
    .wdata     (32'h0),
    .rdata     (mem_rdata),
    .be        (ld_be_unused),
    .wdata_rep (ld_wdata_unused),
    .err       (ld_err),
    .rdata_ext (ld_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_p1    <= 1'b1;
      rd_port    <= 1'b0;
      rd_addr_lo <= 2'b00;
      rd_memop   <= 3'b000;
    end else begin
      state   <= state_nxt;
      last_p1 <= last_p1_nxt;
      if (load_gnt) begin
        rd_port    <= sel;
        rd_addr_lo <= sel_addr[1:0];
        rd_memop   <= sel_memop;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    last_p1_nxt = last_p1;
    load_gnt    = 1'b0;
    p0_gnt      = 1'b0;
    p1_gnt      = 1'b0;
    p0_rvalid   = 1'b0;
    p1_rvalid   = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_be      = 4'b0000;

    case (state)
      ST_IDLE: begin
        if (p0_req || p1_req) begin
          last_p1_nxt = sel;
          p0_gnt      = !sel;
          p1_gnt      = sel;
          if (sel_we) begin
            mem_we = !req_err;
            mem_be = req_err ? 4'b0000 : req_be;
          end else begin
            load_gnt  = 1'b1;
            mem_re    = !req_err;
            state_nxt = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        p0_rvalid = !rd_port;
        p1_rvalid = rd_port;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Reset is synchronous, but the outputs are combinational, so hold them quiet during it.
    if (reset) begin
      load_gnt  = 1'b0;
      p0_gnt    = 1'b0;
      p1_gnt    = 1'b0;
      p0_rvalid = 1'b0;
      p1_rvalid = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
    end
  end

  assign p0_err   = (p0_gnt && sel_we && req_err) || (p0_rvalid && ld_err);
  assign p1_err   = (p1_gnt && sel_we && req_err) || (p1_rvalid && ld_err);
  assign p0_rdata = (p0_rvalid && !ld_err) ? ld_rdata : 32'h0;
  assign p1_rdata = (p1_rvalid && !ld_err) ? ld_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stores, loads, errors, round-robin and reset during a pending load.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [2:0]  p0_memop, p1_memop;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [14:0] mem_addr;
  logic        mem_re, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_AW(15)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_memop(p0_memop),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_memop(p1_memop),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_memop = 3'b010;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_memop = 3'b010;
  endtask

  task automatic drive_p0(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] memop);
    p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_memop = memop;
  endtask

  task automatic drive_p1(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] memop);
    p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_memop = memop;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    mem_rdata = 32'h0;
    drive_p1(1'b1, 32'h8, 32'h1, 3'b010);
    step();
    @(negedge clk);
    checks++; if (p1_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %0b want 0", p1_gnt); end
    checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("FAIL rst_strobes: we=%0b re=%0b want 0 0", mem_we, mem_re); end
    checks++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL rst_be: got %b want 0000", mem_be); end
    checks++; if ({p0_rvalid, p1_rvalid, p0_err, p1_err} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", {p0_rvalid, p1_rvalid, p0_err, p1_err}); end
    checks++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h %h want 0", p0_rdata, p1_rdata); end
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (p1_gnt !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL rst_first_gnt: gnt=%0b we=%0b want 1 1", p1_gnt, mem_we); end
    step();
    idle_inputs();
  endtask

  task automatic test_store_word();
    drive_p0(1'b1, 32'h100, 32'hDEADBEEF, 3'b010);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("FAIL sw_gnt: got %0b%0b want 10", p0_gnt, p1_gnt); end
    checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin errors++; $display("FAIL sw_strobes: we=%0b re=%0b want 1 0", mem_we, mem_re); end
    checks++; if (mem_addr !== 15'h40) begin errors++; $display("FAIL sw_addr: got %h want 0040", mem_addr); end
    checks++; if (mem_be !== 4'b1111 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_lanes: be=%b wdata=%h want 1111 deadbeef", mem_be, mem_wdata); end
    step();
    idle_inputs();
    @(negedge clk);
    checks++; if (p0_rvalid !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'b0000) begin errors++; $display("FAIL sw_after: rvalid=%0b we=%0b be=%b want 0 0 0000", p0_rvalid, mem_we, mem_be); end
    step();
  endtask

  task automatic test_store_half();
    drive_p1(1'b1, 32'h102, 32'h1234ABCD, 3'b001);
    @(negedge clk);
    checks++; if (p1_gnt !== 1'b1 || p1_err !== 1'b0) begin errors++; $display("FAIL sh_gnt: gnt=%0b err=%0b want 1 0", p1_gnt, p1_err); end
    checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_lanes: be=%b wdata=%h want 1100 abcdabcd", mem_be, mem_wdata); end
    step();
    idle_inputs();
    drive_p1(1'b1, 32'h101, 32'h0000005A, 3'b000);
    @(negedge clk);
    checks++; if (mem_be !== 4'b0010 || mem_wdata !== 32'h5A5A5A5A || mem_we !== 1'b1) begin errors++; $display("FAIL sb_lanes: be=%b wdata=%h we=%0b want 0010 5a5a5a5a 1", mem_be, mem_wdata, mem_we); end
    step();
    idle_inputs();
  endtask

  task automatic test_load_byte();
    drive_p1(1'b0, 32'h103, 32'h0, 3'b000);
    @(negedge clk);
    checks++; if (p1_gnt !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL lb_gnt: gnt=%0b re=%0b we=%0b want 1 1 0", p1_gnt, mem_re, mem_we); end
    checks++; if (mem_addr !== 15'h40) begin errors++; $display("FAIL lb_addr: got %h want 0040", mem_addr); end
    step();
    idle_inputs();
    mem_rdata = 32'h80000000;
    @(negedge clk);
    checks++; if (p1_rvalid !== 1'b1 || p0_rvalid !== 1'b0 || p1_err !== 1'b0) begin errors++; $display("FAIL lb_rvalid: p1=%0b p0=%0b err=%0b want 1 0 0", p1_rvalid, p0_rvalid, p1_err); end
    checks++; if (p1_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", p1_rdata); end
    step();
    drive_p1(1'b0, 32'h103, 32'h0, 3'b100);
    step();
    idle_inputs();
    @(negedge clk);
    checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_data: rvalid=%0b data=%h want 1 00000080", p1_rvalid, p1_rdata); end
    step();
  endtask

  task automatic test_load_extend();
    drive_p0(1'b0, 32'h102, 32'h0, 3'b001);
    step();
    idle_inputs();
    mem_rdata = 32'h80011234;
    @(negedge clk);
    checks++; if (p0_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data: got %h want ffff8001", p0_rdata); end
    step();
    drive_p0(1'b0, 32'h102, 32'h0, 3'b101);
    step();
    idle_inputs();
    @(negedge clk);
    checks++; if (p0_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu_data: got %h want 00008001", p0_rdata); end
    step();
    drive_p0(1'b0, 32'h104, 32'h0, 3'b011);
    @(negedge clk);
    checks++; if (mem_re !== 1'b1 || mem_addr !== 15'h41) begin errors++; $display("FAIL lw011_req: re=%0b addr=%h want 1 0041", mem_re, mem_addr); end
    step();
    idle_inputs();
    mem_rdata = 32'h89ABCDEF;
    @(negedge clk);
    checks++; if (p0_rdata !== 32'h89ABCDEF || p0_err !== 1'b0) begin errors++; $display("FAIL lw011_data: data=%h err=%0b want 89abcdef 0", p0_rdata, p0_err); end
    step();
  endtask

  task automatic test_misaligned();
    drive_p0(1'b0, 32'h101, 32'h0, 3'b001);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1 || mem_re !== 1'b0 || p0_err !== 1'b0) begin errors++; $display("FAIL mis_lh_gnt: gnt=%0b re=%0b err=%0b want 1 0 0", p0_gnt, mem_re, p0_err); end
    step();
    idle_inputs();
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++; if (p0_rvalid !== 1'b1 || p0_err !== 1'b1 || p0_rdata !== 32'h0) begin errors++; $display("FAIL mis_lh_resp: rvalid=%0b err=%0b data=%h want 1 1 0", p0_rvalid, p0_err, p0_rdata); end
    step();
    drive_p0(1'b1, 32'h102, 32'h11223344, 3'b010);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1 || p0_err !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b0000) begin errors++; $display("FAIL mis_sw: gnt=%0b err=%0b we=%0b be=%b want 1 1 0 0000", p0_gnt, p0_err, mem_we, mem_be); end
    step();
    idle_inputs();
    drive_p1(1'b1, 32'h100, 32'h11223344, 3'b100);
    @(negedge clk);
    checks++; if (p1_gnt !== 1'b1 || p1_err !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL ill_st: gnt=%0b err=%0b we=%0b want 1 1 0", p1_gnt, p1_err, mem_we); end
    step();
    idle_inputs();
    @(negedge clk);
    checks++; if (p1_rvalid !== 1'b0 || p1_err !== 1'b0) begin errors++; $display("FAIL ill_st_after: rvalid=%0b err=%0b want 0 0", p1_rvalid, p1_err); end
    step();
  endtask

  task automatic test_round_robin();
    logic [7:0] exp0;
    logic [7:0] exp1;
    exp0 = 8'b0001_0001;
    exp1 = 8'b0100_0100;
    reset = 1'b1;
    drive_p0(1'b0, 32'h200, 32'h0, 3'b010);
    drive_p1(1'b0, 32'h300, 32'h0, 3'b010);
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (p0_gnt !== exp0[i] || p1_gnt !== exp1[i]) begin errors++; $display("FAIL rr_cycle%0d: got %0b%0b want %0b%0b", i, p0_gnt, p1_gnt, exp0[i], exp1[i]); end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset_rd_wait();
    drive_p1(1'b0, 32'h10, 32'h0, 3'b010);
    @(negedge clk);
    checks++; if (p1_gnt !== 1'b1 || mem_re !== 1'b1) begin errors++; $display("FAIL rrw_gnt: gnt=%0b re=%0b want 1 1", p1_gnt, mem_re); end
    step();
    idle_inputs();
    reset = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    checks++; if (p1_rvalid !== 1'b0 || p0_rvalid !== 1'b0) begin errors++; $display("FAIL rrw_no_rvalid: p1=%0b p0=%0b want 0 0", p1_rvalid, p0_rvalid); end
    step();
    reset = 1'b0;
    drive_p0(1'b0, 32'h20, 32'h0, 3'b010);
    drive_p1(1'b0, 32'h30, 32'h0, 3'b010);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || mem_addr !== 15'h8) begin errors++; $display("FAIL rrw_regrant: gnt=%0b%0b addr=%h want 10 0008", p0_gnt, p1_gnt, mem_addr); end
    step();
    idle_inputs();
    mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hCAFEF00D || p1_rvalid !== 1'b0) begin errors++; $display("FAIL rrw_resp: rvalid=%0b data=%h p1=%0b want 1 cafef00d 0", p0_rvalid, p0_rdata, p1_rvalid); end
    step();
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_half();
    test_load_byte();
    test_load_extend();
    test_misaligned();
    test_round_robin();
    test_reset_rd_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_AW, default 15: word-address width of the shared data memory.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pN_req  in  1  port N (N=0 CPU, N=1 debug/DMA) request; held until pN_gnt.
REQ-005 pN_we  in  1  1 = store, 0 = load.
REQ-006 pN_addr  in  32  byte address.
REQ-007 pN_wdata  in  32  store data, right-aligned.
REQ-008 pN_memop  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-009 pN_gnt  out  1  one-cycle pulse: request accepted.
REQ-010 pN_rvalid  out  1  one-cycle pulse: load data or error valid.
REQ-011 pN_rdata  out  32  extended load data, valid with pN_rvalid.
REQ-012 pN_err  out  1  misalignment or illegal-op flag, qualified by pN_gnt (store) or pN_rvalid (load).
REQ-013 mem_addr  out  MEM_AW  word address = addr[MEM_AW+1:2].
REQ-014 mem_re / mem_we  out  1 each  memory read / write strobes.
REQ-015 mem_be  out  4  byte-lane write enables.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_rdata  in  32  read data, valid exactly one cycle after mem_re.

Function
REQ-018 FSM states IDLE and RD_WAIT; at most one outstanding access.
REQ-019 IDLE: grant at most one requester per cycle; in RD_WAIT no grants are issued.
REQ-020 Arbitration round-robin: on contention grant the port not granted last; pointer updates only on a grant.
REQ-021 Sole requester is granted in the same cycle its req is seen in IDLE.
REQ-022 Store grant: mem_we=1 and mem_be/mem_wdata driven in the grant cycle; state stays IDLE; no rvalid.
REQ-023 Store lanes: sb be=1<<addr[1:0], data {4{b}}; sh be=addr[1]?1100:0011, data {2{h}}; sw be=1111.
REQ-024 Load grant: mem_re=1 in the grant cycle; IDLE->RD_WAIT.
REQ-025 RD_WAIT: next cycle pN_rvalid=1 for the granted port, rdata lane-selected by latched addr[1:0] and sign/zero-extended per latched memop; RD_WAIT->IDLE.
REQ-026 Load latency: grant cycle + 1; peak load throughput one per 2 cycles.
REQ-027 Misaligned (h with addr[0]=1; w with addr[1:0]!=0) or store memop not in {000,001,010}: grant issued, no mem_re/mem_we, err=1.
REQ-028 Erroneous load still passes through RD_WAIT; rvalid=1, err=1, rdata=0 next cycle.
REQ-029 Load memop 011/110/111 is treated as lw.
REQ-030 All memory strobes are 0 whenever no grant occurs.

Reset
REQ-031 Reset: state IDLE, RR pointer favours port 0, all gnt/rvalid/err/mem_re/mem_we/mem_be = 0, rdata = 0.
REQ-032 Reset during RD_WAIT discards the pending load; no rvalid is produced.
REQ-033 First grant possible in the first cycle after reset deasserts.

Structure
REQ-034 Package dmem_pkg holds the memop encodings and the FSM state encoding.
REQ-035 Sub-module dmem_lane_align (combinational) produces be/wdata replication, misalign error and load extraction/extension; instantiated once for the store path and once for the load path.

Verification
REQ-036 p0 sw addr 0x100, data 0xDEADBEEF, alone -> same-cycle gnt, mem_addr=0x40, be=1111, wdata=0xDEADBEEF.
REQ-037 p1 lb addr 0x103, mem_rdata=0x80000000 -> gnt, next cycle p1_rvalid, rdata=0xFFFFFF80; with lbu -> 0x00000080.
REQ-038 p0 and p1 loads held continuously from reset -> grant order p0,p1,p0,p1, each grant 2 cycles apart.
REQ-039 p0 lh addr 0x101 -> gnt, mem_re=0, next cycle rvalid=1, err=1, rdata=0.
REQ-040 p1 sh addr 0x102, data 0x1234ABCD -> be=1100, wdata=0xABCDABCD.
REQ-041 reset asserted in the RD_WAIT cycle -> no rvalid; next request after reset is granted normally to p0 on contention.
